// File: rtl/io_cond_pkg.sv
// Shared constants and helpers for the board input conditioner.
// Cycle-count defaults assume a 100 MHz CLK.
package io_cond_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;        // 0.5 ms
    localparam int LONG_CYCLES_DEF     = 100_000_000;  // 1 s

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// One button channel: synchroniser, polarity fix, debounce, edge pulses, optional long press.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges pin->level; no backpressure. Long press under IO_COND_LONGPRESS_EN.
module io_debounce
    import io_cond_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int   LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter logic INVERT          = 1'b0
) (
    input  logic CLK,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam int             CW       = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sampled;
    logic [CW-1:0]          cnt;

    assign sampled = sync_chain[SYNC_STAGES-1] ^ INVERT;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            sync_chain <= '0;
            level      <= 1'b0;
            cnt        <= '0;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], pin};
            rise       <= 1'b0;
            fall       <= 1'b0;
            if (sampled == level) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                // Input held different for DEBOUNCE_CYCLES consecutive cycles: accept it.
                level <= sampled;
                cnt   <= '0;
                rise  <= sampled;
                fall  <= ~sampled;
            end
        end
    end

`ifdef IO_COND_LONGPRESS_EN
    localparam int             LW       = clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0]  HOLD_MAX = LW'(LONG_CYCLES);
    localparam logic [LW-1:0]  HOLD_PRE = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] hold_cnt;

    // Saturating at HOLD_MAX is what limits the pulse to one per press.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else if (!level) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            long_press <= (hold_cnt == HOLD_PRE);
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/board_io_cond.sv
// Board input conditioner: master reset generation, per-button debounce, switch sync (IO_COND_LONGPRESS_EN adds btn_long).
// rst_out deasserts RST_STAGES edges after release; switches SYNC_STAGES latency; no backpressure.
module board_io_cond
    import io_cond_pkg::*;
#(
    parameter int                 NUM_BTN         = 6,
    parameter int                 NUM_SW          = 8,
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 RST_STAGES      = 2,
    parameter int                 DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic [NUM_BTN-1:0] BTN_INVERT      = '0,
    parameter int                 LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic               CLK,
    input  logic               reset_trigger,
    input  logic               locked,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_SW-1:0]  sw_raw,
    output logic               rst_out,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_rise,
    output logic [NUM_BTN-1:0] btn_fall,
    output logic [NUM_BTN-1:0] btn_long,
    output logic [NUM_SW-1:0]  sw_sync
);

    logic                  rst_a;
    logic [RST_STAGES-1:0] rst_chain;
    logic [NUM_SW-1:0]     sw_chain [SYNC_STAGES];

    // Losing clock lock is treated exactly like an external reset request.
    assign rst_a   = reset_trigger | ~locked;
    assign rst_out = rst_chain[RST_STAGES-1];

    always_ff @(posedge CLK or posedge rst_a) begin
        if (rst_a) begin
            rst_chain <= '1;
        end else begin
            rst_chain <= rst_chain << 1;
        end
    end

    always_ff @(posedge CLK or posedge rst_out) begin
        if (rst_out) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sw_chain[s] <= '0;
            end
        end else begin
            sw_chain[0] <= sw_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sw_chain[s] <= sw_chain[s-1];
            end
        end
    end

    assign sw_sync = sw_chain[SYNC_STAGES-1];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        io_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .INVERT          (BTN_INVERT[i])
        ) u_debounce (
            .CLK        (CLK),
            .rst        (rst_out),
            .pin        (btn_raw[i]),
            .level      (btn_level[i]),
            .rise       (btn_rise[i]),
            .fall       (btn_fall[i]),
            .long_press (btn_long[i])
        );
    end

endmodule

// File: tb/tb_board_io_cond.sv
// Directed-vector bench for board_io_cond (SYNC=2, RST=2, DEBOUNCE=4, LONG=10, 2 buttons, btn1 active-low).
module tb_board_io_cond;

    logic       CLK = 1'b0;
    logic       reset_trigger;
    logic       locked;
    logic [1:0] btn_raw;
    logic [7:0] sw_raw;
    logic       rst_out;
    logic [1:0] btn_level;
    logic [1:0] btn_rise;
    logic [1:0] btn_fall;
    logic [1:0] btn_long;
    logic [7:0] sw_sync;

    int checks = 0;
    int errors = 0;

    board_io_cond #(
        .NUM_BTN         (2),
        .NUM_SW          (8),
        .SYNC_STAGES     (2),
        .RST_STAGES      (2),
        .DEBOUNCE_CYCLES (4),
        .BTN_INVERT      (2'b10),
        .LONG_CYCLES     (10)
    ) dut (
        .CLK           (CLK),
        .reset_trigger (reset_trigger),
        .locked        (locked),
        .btn_raw       (btn_raw),
        .sw_raw        (sw_raw),
        .rst_out       (rst_out),
        .btn_level     (btn_level),
        .btn_rise      (btn_rise),
        .btn_fall      (btn_fall),
        .btn_long      (btn_long),
        .sw_sync       (sw_sync)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (rst_out !== 1'b1) begin
            errors++; $display("FAIL reset_hold rst_out=%b want 1", rst_out);
        end
        checks++;
        if ({btn_level, btn_rise, btn_fall, btn_long, sw_sync} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs lvl=%b rise=%b fall=%b long=%b sw=%h want 0",
                     btn_level, btn_rise, btn_fall, btn_long, sw_sync);
        end
        reset_trigger = 1'b0;
        tick();
        checks++;
        if (rst_out !== 1'b1) begin
            errors++; $display("FAIL reset_release_edge1 rst_out=%b want 1", rst_out);
        end
        tick();
        checks++;
        if (rst_out !== 1'b0) begin
            errors++; $display("FAIL reset_release_edge2 rst_out=%b want 0", rst_out);
        end
        repeat (4) tick();
        // Pulse between edges: reset must appear with no clock edge.
        reset_trigger = 1'b1;
        #2;
        checks++;
        if (rst_out !== 1'b1) begin
            errors++; $display("FAIL reset_async rst_out=%b want 1", rst_out);
        end
        #1;
        reset_trigger = 1'b0;
        tick();
        checks++;
        if (rst_out !== 1'b1) begin
            errors++; $display("FAIL pulse_release_edge1 rst_out=%b want 1", rst_out);
        end
        tick();
        checks++;
        if (rst_out !== 1'b0) begin
            errors++; $display("FAIL pulse_release_edge2 rst_out=%b want 0", rst_out);
        end
        repeat (4) tick();
    endtask

    task automatic test_lock_drop();
        btn_raw[0] = 1'b1;
        repeat (6) tick();
        checks++;
        if (btn_level[0] !== 1'b1) begin
            errors++; $display("FAIL lock_pre_level lvl0=%b want 1", btn_level[0]);
        end
        locked = 1'b0;
        btn_raw[0] = 1'b0;
        #1;
        checks++;
        if (rst_out !== 1'b1 || btn_level !== 2'b00) begin
            errors++; $display("FAIL lock_drop rst_out=%b lvl=%b want 1 00", rst_out, btn_level);
        end
        repeat (3) tick();
        locked = 1'b1;
        tick();
        checks++;
        if (rst_out !== 1'b1) begin
            errors++; $display("FAIL relock_edge1 rst_out=%b want 1", rst_out);
        end
        tick();
        checks++;
        if (rst_out !== 1'b0) begin
            errors++; $display("FAIL relock_edge2 rst_out=%b want 0", rst_out);
        end
    endtask

    task automatic test_press();
        int rises;
        int falls;
        rises = 0;
        falls = 0;
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            rises += int'(btn_rise[0]);
            falls += int'(btn_fall[0]);
            if (k == 5 || k == 6) begin
                checks++;
                if (btn_level[0] !== (k == 6) || btn_rise[0] !== (k == 6)) begin
                    errors++;
                    $display("FAIL press_edge k=%0d lvl0=%b rise0=%b want %b", k, btn_level[0],
                             btn_rise[0], (k == 6));
                end
            end
        end
        checks++;
        if (rises != 1 || falls != 0) begin
            errors++; $display("FAIL press_pulses rises=%0d falls=%0d want 1 0", rises, falls);
        end
        btn_raw[0] = 1'b0;
        falls = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            falls += int'(btn_fall[0]);
            if (k == 6) begin
                checks++;
                if (btn_fall[0] !== 1'b1 || btn_level[0] !== 1'b0 || btn_rise[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL release_edge fall0=%b lvl0=%b rise0=%b want 1 0 0",
                             btn_fall[0], btn_level[0], btn_rise[0]);
                end
            end
        end
        checks++;
        if (falls != 1) begin
            errors++; $display("FAIL release_pulses falls=%0d want 1", falls);
        end
    endtask

    task automatic test_glitch();
        int rises;
        int falls;
        rises = 0;
        falls = 0;
        for (int k = 0; k < 26; k++) begin
            btn_raw[0] = (k >= 12) ? 1'b1 : ((k % 4) < 2);
            tick();
            rises += int'(btn_rise[0]);
            falls += int'(btn_fall[0]);
            if (k == 11) begin
                checks++;
                if (btn_level[0] !== 1'b0) begin
                    errors++; $display("FAIL glitch_reject lvl0=%b want 0", btn_level[0]);
                end
            end
        end
        checks++;
        if (rises != 1 || falls != 0 || btn_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_settle rises=%0d falls=%0d lvl0=%b want 1 0 1", rises, falls,
                     btn_level[0]);
        end
        btn_raw[0] = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_active_low();
        int rises;
        int longs;
        rises = 0;
        longs = 0;
        btn_raw[1] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            rises += int'(btn_rise[1]);
            longs += int'(btn_long[1]);
`ifdef IO_COND_LONGPRESS_EN
            if (k == 15 || k == 16) begin
                checks++;
                if (btn_long[1] !== (k == 16)) begin
                    errors++; $display("FAIL long_timing k=%0d long1=%b want %b", k, btn_long[1], (k == 16));
                end
            end
`endif
        end
        checks++;
        if (rises != 1 || btn_level[1] !== 1'b1) begin
            errors++; $display("FAIL active_low rises=%0d lvl1=%b want 1 1", rises, btn_level[1]);
        end
        checks++;
`ifdef IO_COND_LONGPRESS_EN
        if (longs != 1) begin
            errors++; $display("FAIL long_count longs=%0d want 1", longs);
        end
`else
        if (longs != 0) begin
            errors++; $display("FAIL long_disabled longs=%0d want 0", longs);
        end
`endif
        btn_raw[1] = 1'b1;
        repeat (8) tick();
        checks++;
        if (btn_level[1] !== 1'b0) begin
            errors++; $display("FAIL active_low_release lvl1=%b want 0", btn_level[1]);
        end
    endtask

    task automatic test_reset_mid();
        btn_raw[0] = 1'b1;
        repeat (4) tick();
        reset_trigger = 1'b1;
        #1;
        checks++;
        if (btn_level !== 2'b00 || rst_out !== 1'b1) begin
            errors++; $display("FAIL mid_reset lvl=%b rst_out=%b want 00 1", btn_level, rst_out);
        end
        tick();
        reset_trigger = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7 || k == 8) begin
                checks++;
                if (btn_level[0] !== (k == 8)) begin
                    errors++;
                    $display("FAIL fresh_count k=%0d lvl0=%b want %b", k, btn_level[0], (k == 8));
                end
            end
        end
        sw_raw = 8'hA5;
        tick();
        checks++;
        if (sw_sync !== 8'h00) begin
            errors++; $display("FAIL sw_edge1 sw=%h want 00", sw_sync);
        end
        tick();
        checks++;
        if (sw_sync !== 8'hA5) begin
            errors++; $display("FAIL sw_edge2 sw=%h want a5", sw_sync);
        end
    endtask

    initial begin
        reset_trigger = 1'b1;
        locked        = 1'b1;
        btn_raw       = 2'b10;
        sw_raw        = 8'h00;
        test_reset();
        test_lock_drop();
        test_press();
        test_glitch();
        test_active_low();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
